// File: rtl/key_input_ctrl_if.sv
// key_input_ctrl_if: CPU value handshake plus digit/busy display signals of key_input_ctrl.
interface key_input_ctrl_if;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ack_i;
  logic [3:0]  tens_o;
  logic [3:0]  ones_o;
  logic        busy_o;
  modport master(output data_o, data_valid_o, tens_o, ones_o, busy_o, input data_ack_i);
  modport slave(input data_o, data_valid_o, tens_o, ones_o, busy_o, output data_ack_i);
endinterface

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: debounce k1/k2/enter, compose a two-digit value and hand it to the CPU; KEY_AUTOREPEAT_EN adds k1/k2 auto-repeat.
module key_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic CLOCK_50,
  input logic rst,
  input logic k1,
  input logic k2,
  input logic enter,
  key_input_ctrl_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic {EDIT, HOLD} state_t;
  state_t        state;
  logic [2:0]    s1, s2, deb, deb_d, press, ev;
  logic [CW-1:0] cnt [3];
  logic [3:0]    tens, ones;
  logic [31:0]   data;
  logic          valid, busy;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("key_input_ctrl: invalid timing parameters");
  end
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= {enter, k2, k1};
      s2    <= s1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rcnt [2];
  logic [1:0]    rep;
  // rcnt==0 means disarmed; a press arms it, each repeat reloads it one period short of the delay
  always_comb for (int i = 0; i < 2; i++) rep[i] = deb[i] && state == EDIT && rcnt[i] == RW'(REPEAT_DELAY);
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !deb[i] || state != EDIT) rcnt[i] <= '0;
      else if (press[i]) rcnt[i] <= RW'(1);
      else if (rep[i]) rcnt[i] <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      else if (rcnt[i] != '0) rcnt[i] <= rcnt[i] + 1'b1;
    end
  end
  assign ev = press | {1'b0, rep};
`else
  assign ev = press;
`endif
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= EDIT;
      tens  <= '0;
      ones  <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else if (state == EDIT) begin
      if (ev[2]) begin
        data  <= 32'(tens) * 32'd10 + 32'(ones);
        valid <= 1'b1;
        busy  <= 1'b1;
        state <= HOLD;
      end else begin
        if (ev[0]) tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        if (ev[1]) ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
      end
    end else if (bus.data_ack_i) begin
      valid <= 1'b0;
      busy  <= 1'b0;
      tens  <= '0;
      ones  <= '0;
      state <= EDIT;
    end
  end
  assign bus.data_o       = data;
  assign bus.data_valid_o = valid;
  assign bus.tens_o       = tens;
  assign bus.ones_o       = ones;
  assign bus.busy_o       = busy;
endmodule

// File: tb/tb_key_input_ctrl.sv
// tb_key_input_ctrl: directed key sequences checked every cycle against a sample-window behavioural model.
module tb_key_input_ctrl;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic CLOCK_50 = 1'b0;
  logic rst = 1'b1;
  logic k1 = 1'b0, k2 = 1'b0, enter = 1'b0;
  bit   started = 1'b0;
  int   checks = 0, errors = 0;
  key_input_ctrl_if bus();
  key_input_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .k1(k1), .k2(k2), .enter(enter), .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  logic [D+1:0] hist [3];
  logic [2:0]   mdeb = '0, r1 = '0, r2 = '0;
  bit           armed [2];
  int           age [2];
  int           m_tens = 0, m_ones = 0, m_data = 0;
  bit           m_valid = 0, m_hold = 0;
  // Key level accepted once the last D synchronised samples (raw delayed two edges) all disagree with it;
  // a rising level acts on the digits two edges later.
  always @(posedge CLOCK_50) begin
    logic [2:0] raw, rep, ev, rose;
    bit hold_pre;
    raw = {enter, k2, k1};
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      for (int i = 0; i < 2; i++) begin armed[i] = 0; age[i] = 0; end
      mdeb = '0; r1 = '0; r2 = '0;
      m_tens = 0; m_ones = 0; m_data = 0; m_valid = 0; m_hold = 0;
    end else begin
      ev = r2;
      rep = '0;
      hold_pre = m_hold;
      for (int i = 0; i < 2; i++) if (armed[i]) begin
        age[i]++;
        rep[i] = AR && !hold_pre && mdeb[i] && age[i] >= RD && (age[i] - RD) % RP == 0;
        if (!mdeb[i] || hold_pre) armed[i] = 0;
      end
      if (!hold_pre) begin
        if (ev[2]) begin
          m_data = m_tens * 10 + m_ones; m_valid = 1; m_hold = 1;
        end else begin
          if (ev[0] | rep[0]) m_tens = (m_tens + 1) % 10;
          if (ev[1] | rep[1]) m_ones = (m_ones + 1) % 10;
        end
        for (int i = 0; i < 2; i++) if (AR && ev[i] && mdeb[i]) begin armed[i] = 1; age[i] = 0; end
      end else if (bus.data_ack_i) begin
        m_valid = 0; m_hold = 0; m_tens = 0; m_ones = 0;
      end
      rose = '0;
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][D:0], raw[i]};
        if (hist[i][D+1:2] == {D{~mdeb[i]}}) begin
          mdeb[i] = ~mdeb[i];
          rose[i] = mdeb[i];
        end
      end
      r2 = r1;
      r1 = rose;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLOCK_50) if (started) begin
    chk("data_o", bus.data_o, 32'(m_data));
    chk("data_valid_o", 32'(bus.data_valid_o), 32'(m_valid));
    chk("busy_o", 32'(bus.busy_o), 32'(m_hold));
    chk("tens_o", 32'(bus.tens_o), 32'(m_tens));
    chk("ones_o", 32'(bus.ones_o), 32'(m_ones));
  end
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic push(input logic [2:0] mask, input int hi, input int lo);
    {enter, k2, k1} = mask;
    repeat (hi) tick();
    {enter, k2, k1} = 3'b000;
    repeat (lo) tick();
  endtask
  task automatic ack_pulse();
    bus.data_ack_i = 1'b1;
    tick();
    bus.data_ack_i = 1'b0;
  endtask
  initial begin
    bus.data_ack_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    started = 1'b1;
    chk("reset data", bus.data_o, 0);
    chk("reset valid", 32'(bus.data_valid_o), 0);
    chk("reset tens", 32'(bus.tens_o), 0);
    chk("reset ones", 32'(bus.ones_o), 0);
    repeat (3) push(3'b001, 8, 8);
    repeat (6) push(3'b010, 8, 8);
    k2 = 1'b1;
    repeat (7) tick();
    chk("latency edge6 ones", 32'(bus.ones_o), 6);
    tick();
    chk("latency edge7 ones", 32'(bus.ones_o), 7);
    k2 = 1'b0;
    repeat (8) tick();
    chk("3/7 tens", 32'(bus.tens_o), 3);
    chk("3/7 valid", 32'(bus.data_valid_o), 0);
    push(3'b001, 8, 8);
    repeat (5) push(3'b010, 8, 8);
    push(3'b100, 8, 8);
    chk("enter data", bus.data_o, 42);
    chk("enter valid", 32'(bus.data_valid_o), 1);
    chk("enter busy", 32'(bus.busy_o), 1);
    repeat (50) tick();
    chk("held data", bus.data_o, 42);
    chk("held ones", 32'(bus.ones_o), 2);
    ack_pulse();
    chk("ack valid", 32'(bus.data_valid_o), 0);
    chk("ack tens", 32'(bus.tens_o), 0);
    chk("ack data kept", bus.data_o, 42);
    repeat (9) push(3'b001, 8, 8);
    chk("tens 9", 32'(bus.tens_o), 9);
    push(3'b001, 8, 8);
    chk("tens wrap", 32'(bus.tens_o), 0);
    push(3'b010, 3, 10);
    chk("glitch ones", 32'(bus.ones_o), 0);
    ack_pulse();
    chk("ack in edit valid", 32'(bus.data_valid_o), 0);
    push(3'b001, 8, 8);
    push(3'b100, 8, 8);
    chk("hold entry data", bus.data_o, 10);
    push(3'b001, 8, 8);
    push(3'b010, 8, 8);
    push(3'b100, 8, 8);
    chk("hold tens", 32'(bus.tens_o), 1);
    chk("hold ones", 32'(bus.ones_o), 0);
    chk("hold data", bus.data_o, 10);
    ack_pulse();
    push(3'b010, 8, 8);
    chk("post-ack ones", 32'(bus.ones_o), 1);
    repeat (5) push(3'b001, 8, 8);
    repeat (4) push(3'b010, 8, 8);
    push(3'b101, 8, 8);
    chk("k1+enter data", bus.data_o, 55);
    chk("k1+enter tens", 32'(bus.tens_o), 5);
    chk("k1+enter valid", 32'(bus.data_valid_o), 1);
    rst = 1'b1;
    tick();
    chk("mid rst data", bus.data_o, 0);
    chk("mid rst valid", 32'(bus.data_valid_o), 0);
    chk("mid rst busy", 32'(bus.busy_o), 0);
    chk("mid rst tens", 32'(bus.tens_o), 0);
    rst = 1'b0;
    repeat (2) tick();
    k2 = 1'b1;
    repeat (48) tick();
    chk("autorepeat ones", 32'(bus.ones_o), AR ? 4 : 1);
    k2 = 1'b0;
    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
Front-panel input controller between the board push-buttons (k1, k2, enter) and the CPU's input port. It synchronises and debounces the three keys and lets the user compose a two-digit decimal value: k1 steps the tens digit, k2 steps the ones digit. Enter hands the value to the CPU over a valid/ack handshake. The block is clocked from the 50 MHz board clock in the cpu top level.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a key level is accepted (20 ms at 50 MHz); minimum 2.
REPEAT_DELAY, 25000000, cycles a key is held before the first auto-repeat (KEY_AUTOREPEAT_EN only).
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats (KEY_AUTOREPEAT_EN only).

Ports:
CLOCK_50  input  1  system clock; all logic on the rising edge
rst  input  1  reset; synchronous, active-high (1 = reset, the `RstEnable level)
k1  input  1  raw tens key, active-high, asynchronous
k2  input  1  raw ones key, active-high, asynchronous
enter  input  1  raw enter key, active-high, asynchronous
data_ack_i  input  1  CPU acknowledges data_o
data_o  output  32  entered value, binary, zero-extended, range 0..99
data_valid_o  output  1  data_o is valid and awaiting ack
tens_o  output  4  current tens digit, BCD, for display
ones_o  output  4  current ones digit, BCD, for display
busy_o  output  1  high in HOLD state; key edits are ignored

Behaviour:
- Reset: all outputs 0, both synchronisers 0, debounced levels 0, counters 0, state EDIT.
- A key still held when rst drops is a new press; it is reported after the normal debounce time.
- Sync: each key passes through a 2-flop synchroniser.
- Debounce, per key:
  - A counter runs while the synchronised level differs from the debounced level.
  - The counter clears whenever the synchronised level equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Press pulse: one cycle, on the debounced 0->1 transition only. Releases produce no event.
- Latency, raw key high from edge 0: press pulse in the cycle after edge 2+DEBOUNCE_CYCLES; the register updates at edge 3+DEBOUNCE_CYCLES.
- Raw glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: EDIT, HOLD.
- EDIT:
  - k1 press: tens <= (tens==9) ? 0 : tens+1.
  - k2 press: ones <= (ones==9) ? 0 : ones+1.
  - k1 and k2 pressed in the same cycle: both digits update.
  - enter press: data_o <= tens*10+ones; data_valid_o <= 1; busy_o <= 1; go to HOLD.
  - enter in the same cycle as k1/k2: the pre-increment digits are captured and the increments are dropped.
- HOLD:
  - k1, k2 and enter presses are discarded. Debounce keeps tracking, so releases and re-presses are not queued.
  - data_ack_i high: data_valid_o <= 0, busy_o <= 0, tens <= 0, ones <= 0, go to EDIT.
  - data_o keeps its value until the next enter.
- data_ack_i is ignored in EDIT.
- data_valid_o stays high until acked, with no timeout.
- Reset mid-operation (any state, including HOLD with valid high) returns everything to its reset values on the next edge. No ack is required.
- tens_o and ones_o are direct register outputs; they are never outside 0..9.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined:
  - In EDIT, k1 or k2 held debounced-high produces its first repeat press REPEAT_DELAY cycles after the original press pulse.
  - Further repeat presses follow every REPEAT_PERIOD cycles until release.
  - The repeat timer clears on release, on entering HOLD, and on rst.
  - enter never repeats.
- Undefined: exactly one press per debounced push. The repeat counters and both REPEAT parameters are unused and no logic is generated for them.

Test Plan:
(All with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.)
- Reset, then 3 clean k1 pushes and 7 clean k2 pushes -> tens_o=3, ones_o=7, data_valid_o=0. Each update occurs exactly 7 cycles after the raw rising edge.
- Digits 4/2, enter pushed -> data_o=42, data_valid_o=1, busy_o=1. Hold ack 0 for 50 cycles: outputs stable. Pulse data_ack_i -> next cycle data_valid_o=0, tens_o=0, ones_o=0, data_o still 42.
- 10 k1 pushes from 0 -> tens_o wraps to 0. A 3-cycle k2 glitch -> ones_o unchanged.
- In HOLD, push k1, k2 and enter -> digits and data_o unchanged. After ack, exactly one k2 push gives ones_o=1.
- k1 and enter debounced in the same cycle with digits 5/5 -> data_o=55, tens_o stays 5. Assert rst while data_valid_o=1 -> all outputs 0 next cycle.
- KEY_AUTOREPEAT_EN defined, k2 held 44 cycles after its press pulse -> ones_o=4 (1 press + repeats at 20, 28, 36). Without the macro -> ones_o=1.
